// File: rtl/lc3_stack_seq.sv
// LC-3 stack sequencer: interrupt-entry push and RTI pop of PSR/PC via R6,
// including the user/supervisor stack-pointer swap through Saved_USP/SSP.
//
// Optional feature macro: LC3_STACK_TIMEOUT_EN
//   defined   -> memory-wait watchdog of TIMEOUT_CYCLES cycles, aborts to IDLE
//                with a one-cycle mem_timeout pulse (no done pulse)
//   undefined -> memory states wait indefinitely, mem_timeout tied to 0
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   int_req, rti_req      level requests, sampled only in IDLE (int wins)
//   psr_user              current PSR[15]
//   mdr_psr_user          bit 15 of the word read in POP_PSR
//   mem_ready             memory access complete
//   LDSavedUSP/SSP        load saved stack pointers from SR1OUT
//   GateSP, SPMUX, ld_r6  SP-mux onto bus and load R6
//   sr1_r6                force SR1 address to R6
//   mem_en, mem_we        memory access and direction
//   data_sel              0 = PSR, 1 = PC
//   busy, done            not-idle flag, completion pulse
//   priv_viol             RTI attempted in user mode
//   mem_timeout           watchdog abort pulse
module lc3_stack_seq #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       int_req,
    input  logic       rti_req,
    input  logic       psr_user,
    input  logic       mdr_psr_user,
    input  logic       mem_ready,
    output logic       LDSavedUSP,
    output logic       LDSavedSSP,
    output logic       GateSP,
    output logic [1:0] SPMUX,
    output logic       sr1_r6,
    output logic       ld_r6,
    output logic       mem_en,
    output logic       mem_we,
    output logic       data_sel,
    output logic       busy,
    output logic       done,
    output logic       priv_viol,
    output logic       mem_timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SAVE_USP,
        ST_LOAD_SSP,
        ST_DEC1,
        ST_PUSH_PSR,
        ST_DEC2,
        ST_PUSH_PC,
        ST_POP_PC,
        ST_INC1,
        ST_POP_PSR,
        ST_INC2,
        ST_SAVE_SSP,
        ST_LOAD_USP,
        ST_VIOL,
        ST_FIN
`ifdef LC3_STACK_TIMEOUT_EN
        ,
        ST_TMO
`endif
    } state_e;

    state_e state_q, state_d;
    logic   psr_q, psr_d;
    logic   mem_wait;

    assign mem_wait = (state_q == ST_PUSH_PSR) || (state_q == ST_PUSH_PC) ||
                      (state_q == ST_POP_PC)   || (state_q == ST_POP_PSR);

`ifdef LC3_STACK_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          expire;

    // cnt_q holds the number of completed wait cycles in the current
    // memory state; no two memory states are adjacent, so leaving one
    // always passes through a zeroing cycle before the next entry.
    assign expire = mem_wait && !mem_ready && (cnt_q == LIMIT);
`endif

    always_comb begin
        state_d = state_q;
        psr_d   = psr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (int_req) begin
                    state_d = psr_user ? ST_SAVE_USP : ST_DEC1;
                end else if (rti_req) begin
                    state_d = psr_user ? ST_VIOL : ST_POP_PC;
                end
            end
            ST_SAVE_USP: state_d = ST_LOAD_SSP;
            ST_LOAD_SSP: state_d = ST_DEC1;
            ST_DEC1:     state_d = ST_PUSH_PSR;
            ST_PUSH_PSR: if (mem_ready) state_d = ST_DEC2;
            ST_DEC2:     state_d = ST_PUSH_PC;
            ST_PUSH_PC:  if (mem_ready) state_d = ST_FIN;
            ST_POP_PC:   if (mem_ready) state_d = ST_INC1;
            ST_INC1:     state_d = ST_POP_PSR;
            ST_POP_PSR: begin
                if (mem_ready) begin
                    psr_d   = mdr_psr_user;
                    state_d = ST_INC2;
                end
            end
            ST_INC2:     state_d = psr_q ? ST_SAVE_SSP : ST_FIN;
            ST_SAVE_SSP: state_d = ST_LOAD_USP;
            ST_LOAD_USP: state_d = ST_FIN;
            ST_VIOL:     state_d = ST_IDLE;
            ST_FIN:      state_d = ST_IDLE;
`ifdef LC3_STACK_TIMEOUT_EN
            ST_TMO:      state_d = ST_IDLE;
`endif
            default:     state_d = ST_IDLE;
        endcase
`ifdef LC3_STACK_TIMEOUT_EN
        if (expire) begin
            state_d = ST_TMO;
        end
`endif
    end

`ifdef LC3_STACK_TIMEOUT_EN
    always_comb begin
        cnt_d = '0;
        if (mem_wait && (state_d == state_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            psr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            psr_q   <= psr_d;
        end
    end

    // Moore output decode
    always_comb begin
        LDSavedUSP = 1'b0;
        LDSavedSSP = 1'b0;
        GateSP     = 1'b0;
        SPMUX      = 2'b00;
        sr1_r6     = 1'b0;
        ld_r6      = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        data_sel   = 1'b0;
        done       = 1'b0;
        priv_viol  = 1'b0;
        unique case (state_q)
            ST_SAVE_USP: begin
                sr1_r6     = 1'b1;
                LDSavedUSP = 1'b1;
            end
            ST_LOAD_SSP: begin
                SPMUX  = 2'b11;
                GateSP = 1'b1;
                ld_r6  = 1'b1;
            end
            ST_DEC1, ST_DEC2: begin
                sr1_r6 = 1'b1;
                SPMUX  = 2'b10;
                GateSP = 1'b1;
                ld_r6  = 1'b1;
            end
            ST_PUSH_PSR: begin
                mem_en = 1'b1;
                mem_we = 1'b1;
            end
            ST_PUSH_PC: begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                data_sel = 1'b1;
            end
            ST_POP_PC: begin
                mem_en   = 1'b1;
                data_sel = 1'b1;
            end
            ST_POP_PSR: mem_en = 1'b1;
            ST_INC1, ST_INC2: begin
                sr1_r6 = 1'b1;
                SPMUX  = 2'b01;
                GateSP = 1'b1;
                ld_r6  = 1'b1;
            end
            ST_SAVE_SSP: begin
                sr1_r6     = 1'b1;
                LDSavedSSP = 1'b1;
            end
            ST_LOAD_USP: begin
                SPMUX  = 2'b00;
                GateSP = 1'b1;
                ld_r6  = 1'b1;
            end
            ST_VIOL: priv_viol = 1'b1;
            ST_FIN:  done      = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

`ifdef LC3_STACK_TIMEOUT_EN
    assign mem_timeout = (state_q == ST_TMO);
`else
    assign mem_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_lc3_stack_seq.sv
// Randomized bench for lc3_stack_seq: a small register/memory environment
// follows the control outputs and final state is compared to a stack model.
module tb_lc3_stack_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       int_req = 1'b0;
    logic       rti_req = 1'b0;
    logic       psr_user = 1'b0;
    logic       mdr_psr_user;
    logic       mem_ready = 1'b0;
    logic       LDSavedUSP, LDSavedSSP, GateSP, sr1_r6, ld_r6;
    logic [1:0] SPMUX;
    logic       mem_en, mem_we, data_sel;
    logic       busy, done, priv_viol, mem_timeout;

    lc3_stack_seq #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .int_req(int_req), .rti_req(rti_req),
        .psr_user(psr_user), .mdr_psr_user(mdr_psr_user),
        .mem_ready(mem_ready),
        .LDSavedUSP(LDSavedUSP), .LDSavedSSP(LDSavedSSP),
        .GateSP(GateSP), .SPMUX(SPMUX),
        .sr1_r6(sr1_r6), .ld_r6(ld_r6),
        .mem_en(mem_en), .mem_we(mem_we), .data_sel(data_sel),
        .busy(busy), .done(done), .priv_viol(priv_viol),
        .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic        ds;
        logic [15:0] data;
    } acc_t;

    // environment: R6, saved SPs, memory access log
    logic [15:0] r6, susp, sssp;
    logic [15:0] i_r6, i_susp, i_sssp;
    logic [15:0] seed, pc_val, psr_val;
    logic        ld_env = 1'b0;
    logic        rdy_hold = 1'b0;
    logic [15:0] sr1, spm, bus, rd_word;
    acc_t        acc_q[$];

    assign sr1     = sr1_r6 ? r6 : 16'hBAD0;
    assign bus     = GateSP ? spm : 16'hDEAD;
    assign rd_word = r6 ^ seed;
    assign mdr_psr_user = rd_word[15];

    always_comb begin
        spm = susp;
        case (SPMUX)
            2'b00: spm = susp;
            2'b01: spm = sr1 + 16'd1;
            2'b10: spm = sr1 - 16'd1;
            2'b11: spm = sssp;
            default: spm = susp;
        endcase
    end

    always @(posedge clk) begin
        if (ld_env) begin
            r6   <= i_r6;
            susp <= i_susp;
            sssp <= i_sssp;
        end else begin
            if (ld_r6) r6 <= bus;
            if (LDSavedUSP) susp <= sr1;
            if (LDSavedSSP) sssp <= sr1;
            if (mem_en && mem_ready) begin
                acc_t a;
                a.addr = r6;
                a.we   = mem_we;
                a.ds   = data_sel;
                a.data = mem_we ? (data_sel ? pc_val : psr_val) : rd_word;
                acc_q.push_back(a);
            end
        end
    end

    always @(negedge clk) begin
        mem_ready = rdy_hold ? 1'b0 : ($urandom_range(0, 2) == 0);
    end

    // per-cycle monitor counters
    int n_done = 0, n_viol = 0, n_busy = 0, n_le = 0, n_idle = 0;
    logic [13:0] outs;
    assign outs = {LDSavedUSP, LDSavedSSP, GateSP, SPMUX, sr1_r6, ld_r6,
                   mem_en, mem_we, data_sel, busy, done, priv_viol,
                   mem_timeout};

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) n_done++;
            if (priv_viol) n_viol++;
            if (busy) n_busy++;
            if ((int'(LDSavedUSP) + int'(LDSavedSSP) + int'(ld_r6) > 1) ||
                (GateSP != ld_r6)) n_le++;
            if (!busy && outs != 14'd0) n_idle++;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input bit noisy, output bit to);
        to = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (!busy) begin
                to = 1'b0;
                break;
            end
            if (noisy && !done && !priv_viol) begin
                int_req = 1'($urandom_range(0, 1));
                rti_req = 1'($urandom_range(0, 1));
            end else begin
                int_req = 1'b0;
                rti_req = 1'b0;
            end
            @(negedge clk);
        end
        int_req = 1'b0;
        rti_req = 1'b0;
    endtask

    task automatic load_env(input logic [15:0] r0, us0, ss0, sd);
        @(negedge clk);
        i_r6   = r0;
        i_susp = us0;
        i_sssp = ss0;
        seed   = sd;
        pc_val = 16'($urandom);
        psr_val = 16'($urandom);
        ld_env = 1'b1;
        @(negedge clk);
        ld_env = 1'b0;
    endtask

    // kind: 0 = interrupt, 1 = RTI, 2 = both requested together
    task automatic run_txn(input int kind, input bit user,
                           input logic [15:0] r0, us0, ss0, sd,
                           input string nm);
        int b_done, b_viol, b_busy, b_le, b_idle, b_q;
        bit to, isint;
        logic [15:0] er6, eus, ess, base, pa;
        int e_done, e_viol;
        acc_t ea[$];
        acc_t t;

        load_env(r0, us0, ss0, sd);
        #1;
        b_done = n_done; b_viol = n_viol; b_busy = n_busy;
        b_le = n_le; b_idle = n_idle; b_q = acc_q.size();
        psr_user = user;
        int_req = (kind != 1);
        rti_req = (kind != 0);
        @(negedge clk);
        int_req = 1'b0;
        rti_req = 1'b0;
        wait_idle(1'b1, to);
        #1;

        // stack model
        isint = (kind != 1);
        er6 = r0; eus = us0; ess = ss0;
        e_done = 1; e_viol = 0;
        if (isint) begin
            base = user ? ss0 : r0;
            if (user) eus = r0;
            er6 = base - 16'd2;
            t.addr = base - 16'd1; t.we = 1; t.ds = 0; t.data = psr_val;
            ea.push_back(t);
            t.addr = base - 16'd2; t.we = 1; t.ds = 1; t.data = pc_val;
            ea.push_back(t);
        end else if (user) begin
            e_done = 0;
            e_viol = 1;
        end else begin
            t.addr = r0; t.we = 0; t.ds = 1; t.data = r0 ^ sd;
            ea.push_back(t);
            pa = r0 + 16'd1;
            t.addr = pa; t.we = 0; t.ds = 0; t.data = pa ^ sd;
            ea.push_back(t);
            if (t.data[15]) begin
                ess = r0 + 16'd2;
                er6 = us0;
            end else begin
                er6 = r0 + 16'd2;
            end
        end

        check({nm, ".timeout"}, 32'(to), 32'd0);
        check({nm, ".done"}, n_done - b_done, e_done);
        check({nm, ".viol"}, n_viol - b_viol, e_viol);
        check({nm, ".r6"}, r6, er6);
        check({nm, ".usp"}, susp, eus);
        check({nm, ".ssp"}, sssp, ess);
        check({nm, ".le"}, n_le - b_le, 0);
        check({nm, ".idle"}, n_idle - b_idle, 0);
        if (e_viol == 1) check({nm, ".busy"}, n_busy - b_busy, 1);
        check({nm, ".nacc"}, acc_q.size() - b_q, ea.size());
        for (int i = 0; i < ea.size() && b_q + i < acc_q.size(); i++) begin
            t = acc_q[b_q + i];
            check($sformatf("%s.a%0d", nm, i),
                  {t.we, t.ds, t.addr, t.data[12:0]},
                  {ea[i].we, ea[i].ds, ea[i].addr, ea[i].data[12:0]});
            check($sformatf("%s.d%0d", nm, i), t.data, ea[i].data);
        end
    endtask

    bit to;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.outs", outs, 14'd0);
        rst_n = 1'b1;

        run_txn(0, 1, 16'h3000, 16'h1111, 16'h3000, 16'h0000, "int_user");
        run_txn(0, 0, 16'h2FF0, 16'h1234, 16'h4000, 16'h0000, "int_sup");
        run_txn(1, 0, 16'h2FFE, 16'hFE00, 16'h0555, 16'h8000, "rti_user");
        run_txn(1, 0, 16'h2FFE, 16'hFE00, 16'h0555, 16'h0000, "rti_sup");
        run_txn(1, 1, 16'h2FFE, 16'hFE00, 16'h0555, 16'h8000, "rti_viol");
        run_txn(2, 1, 16'h3000, 16'h2222, 16'h5000, 16'h8000, "both");

        // reset during PUSH_PSR wait
        rdy_hold = 1'b1;
        load_env(16'h2F00, 16'h0100, 16'h3000, 16'h0000);
        psr_user = 1'b0;
        int_req = 1'b1;
        @(negedge clk);
        int_req = 1'b0;
        for (int c = 0; c < 20 && !mem_en; c++) @(negedge clk);
        check("rst.push", {mem_en, mem_we, data_sel}, 3'b110);
        #2 rst_n = 1'b0;
        #1 check("rst.async", outs, 14'd0);
        @(negedge clk);
        check("rst.held", outs, 14'd0);
        rdy_hold = 1'b0;
        psr_user = 1'b1;
        int_req = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst.accept", {busy, LDSavedUSP}, 2'b11);
        int_req = 1'b0;
        @(negedge clk);
        wait_idle(1'b0, to);
        check("rst.finish", 32'(to), 32'd0);

        for (int i = 0; i < 40; i++) begin
            run_txn($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                    16'($urandom), 16'($urandom), 16'($urandom),
                    16'($urandom), $sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
